lcd_timing_driver: RTL
======================

// Module: lcd_timing_driver
// PURPOSE
//  Raster timing generator for the LCD/VGA path; sits directly upstream of the pixel source.
//  Produces hsync/vsync/data-enable and the pixel coordinates (lcd_xpos/lcd_ypos) the pixel source uses to fetch image data.
//  Takes back the 24-bit pixel (lcd_data) after a fixed fetch latency and drives it, aligned and blanked, to the panel pins.
// PARAMETERS
//  H_SYNC        96   hsync pulse width, pixels
//  H_BACK        48   horizontal back porch
//  H_DISP        640  active pixels per line
//  H_FRONT       16   horizontal front porch (H_TOTAL = sum = 800, must be <= 2048)
//  V_SYNC        2    vsync width, lines
//  V_BACK        33   vertical back porch
//  V_DISP        480  active lines
//  V_FRONT       10   vertical front porch (V_TOTAL = 525, must be <= 2048)
//  SYNC_POL      0    sync active level: 0 = active-low, 1 = active-high
//  DATA_LATENCY  1    cycles from lcd_xpos/lcd_ypos to matching lcd_data (1..4)
// PORTS
//  iCLK         in   1   pixel clock; sole clock
//  iRST_N       in   1   asynchronous, active-low reset
//  lcd_data     in   24  pixel from pixel source, {R,G,B}, valid DATA_LATENCY cycles after its coordinate
//  lcd_xpos     out  11  column being requested, 0..H_DISP-1; 0 outside request window
//  lcd_ypos     out  11  row being requested, 0..V_DISP-1; 0 outside active lines
//  lcd_request  out  1   high while lcd_xpos/lcd_ypos address a real pixel
//  lcd_hs       out  1   horizontal sync to panel
//  lcd_vs       out  1   vertical sync to panel
//  lcd_de       out  1   data enable to panel
//  lcd_rgb      out  24  pixel to panel; 0 when lcd_de low
//  frame_start  out  1   one-cycle pulse at h_cnt=0, v_cnt=0
// BEHAVIOUR
//  Reset (async, iRST_N=0): h_cnt=v_cnt=0; lcd_hs=lcd_vs=~SYNC_POL; lcd_de=0; lcd_rgb=0;
//   lcd_xpos=lcd_ypos=0; lcd_request=0; frame_start=0; latency pipe cleared. Release resumes at h=v=0.
//  Counters: h_cnt 0..H_TOTAL-1, wraps to 0; v_cnt increments only on h wrap, wraps 0 after V_TOTAL-1.
//  Regions per axis (from count 0): sync [0,SYNC), back porch, display [SYNC+BACK, SYNC+BACK+DISP), front porch.
//  Request window: v_cnt in vertical display AND h_cnt in [HS+HB-DATA_LATENCY, HS+HB-DATA_LATENCY+H_DISP).
//   lcd_request, lcd_xpos = h_cnt-(HS+HB-DATA_LATENCY), lcd_ypos = v_cnt-(VS+VB): decoded from
//   counter registers, same cycle as the count; outside window xpos=0, request=0; ypos=0 outside active lines.
//  Alignment: raw hs/vs/de decoded from counters; de raw = both axes in display. lcd_data for the
//   pixel requested at cycle n arrives at n+DATA_LATENCY, exactly when raw de for that pixel is high.
//  Output stage: one register on lcd_hs, lcd_vs, lcd_de, lcd_rgb (all pins = raw + 1 cycle, mutually aligned).
//   lcd_rgb <= raw_de ? lcd_data : 24'h0.
//  vsync edges coincide with h_cnt=0 (line start); hsync continues during vertical blanking.
//  frame_start registered: high one cycle after counters reach (0,0); exactly once per frame.
//  Width rules: counters and coordinates 11 bits, unsigned; no arithmetic on lcd_data.
//  Boundaries: last pixel x=H_DISP-1 requested at h=HS+HB-L+H_DISP-1; request drops next cycle.
//   Simultaneous h and v wrap: both to 0 same edge, frame_start follows. Mid-frame reset: immediate
//   blank (de=0, rgb=0), syncs inactive; no partial-line recovery.
// STRUCTURE
//  Package lcd_timing_pkg: timing constant sets for 640x480@60 (above) and 1024x768@60
//   (136/160/1024/24, 6/29/768/3), coordinate width 11, sync polarity constants.
//  Sub-module lcd_axis_counter (params SYNC,BACK,DISP,FRONT,LEAD): count, wrap flag, sync/display/
//   request decode; instantiated once for H (enable=1) and once for V (enable=H wrap).
//  Top: latency-free decode, DATA_LATENCY is absorbed by request lead; output register stage.
// TESTING
//  Reset held 10 cycles, release -> all outputs at reset values, lcd_hs=1, first hs low pulse 96 clk wide, period 800.
//  Run one frame -> frame_start seen once every 420000 clk; lcd_vs low for 1600 clk; 480 lines with de high 640 clk each.
//  Model ROM data = {ypos[7:0],xpos[10:0],5'b0} with 1-cycle latency -> every lcd_de=1 cycle carries matching
//   coordinate; first pixel of line 0 is 24'h000000, last is x=639; lcd_request first high at h=143.
//  lcd_data forced 24'hFFFFFF constantly -> lcd_rgb==0 whenever lcd_de==0, ==FFFFFF when lcd_de==1.
//  DATA_LATENCY=2 model -> request starts h=142, pixels still aligned with lcd_de, no off-by-one at x=0/639.
//  Assert iRST_N low at line 200 x=300 for 3 clk -> outputs blank immediately; after release frame restarts, frame_start in 420000 clk.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared constants and types for the LCD raster timing driver:
// standard timing sets, coordinate width, sync polarity and pixel layout.
package lcd_timing_pkg;

  localparam int unsigned COORD_W = 11;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int unsigned T640_H_SYNC  = 96;
  localparam int unsigned T640_H_BACK  = 48;
  localparam int unsigned T640_H_DISP  = 640;
  localparam int unsigned T640_H_FRONT = 16;
  localparam int unsigned T640_V_SYNC  = 2;
  localparam int unsigned T640_V_BACK  = 33;
  localparam int unsigned T640_V_DISP  = 480;
  localparam int unsigned T640_V_FRONT = 10;

  // 1024x768 @ 60 Hz, 65 MHz pixel clock
  localparam int unsigned T1024_H_SYNC  = 136;
  localparam int unsigned T1024_H_BACK  = 160;
  localparam int unsigned T1024_H_DISP  = 1024;
  localparam int unsigned T1024_H_FRONT = 24;
  localparam int unsigned T1024_V_SYNC  = 6;
  localparam int unsigned T1024_V_BACK  = 29;
  localparam int unsigned T1024_V_DISP  = 768;
  localparam int unsigned T1024_V_FRONT = 3;

  typedef enum logic [1:0] {
    REGION_SYNC,
    REGION_BACK,
    REGION_DISP,
    REGION_FRONT
  } axis_region_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int unsigned axis_total(input int unsigned sync, input int unsigned back,
                                             input int unsigned disp, input int unsigned front);
    return sync + back + disp + front;
  endfunction

endpackage

// File: rtl/lcd_timing_driver_axis_counter.sv
// One raster axis: free-running counter with wrap flag plus region and
// request-window decode. The request window leads the display window by LEAD counts.
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned SYNC  = 96,
  parameter int unsigned BACK  = 48,
  parameter int unsigned DISP  = 640,
  parameter int unsigned FRONT = 16,
  parameter int unsigned LEAD  = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  output logic               wrap_o,
  output logic               sync_o,
  output logic               disp_o,
  output logic               req_o,
  output logic [COORD_W-1:0] pos_o
);

  localparam int unsigned TOTAL = axis_total(SYNC, BACK, DISP, FRONT);
  localparam int unsigned XW    = COORD_W + 1;

  localparam logic [COORD_W-1:0] LAST      = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] REQ_BASE  = COORD_W'(SYNC + BACK - LEAD);
  // One extra bit so window ends equal to 2048 still compare correctly.
  localparam logic [XW-1:0]      SYNC_END  = XW'(SYNC);
  localparam logic [XW-1:0]      DISP_BEG  = XW'(SYNC + BACK);
  localparam logic [XW-1:0]      DISP_END  = XW'(SYNC + BACK + DISP);
  localparam logic [XW-1:0]      REQ_BEG   = XW'(SYNC + BACK - LEAD);
  localparam logic [XW-1:0]      REQ_END   = XW'(SYNC + BACK - LEAD + DISP);

  logic [COORD_W-1:0] cnt_q;
  logic [COORD_W-1:0] cnt_d;
  logic [XW-1:0]      cnt_x;
  axis_region_e       region;

  assign cnt_x = {1'b0, cnt_q};

  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = en_i && (cnt_q == LAST);
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + COORD_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    region = REGION_FRONT;
    if (cnt_x < SYNC_END) begin
      region = REGION_SYNC;
    end else if (cnt_x < DISP_BEG) begin
      region = REGION_BACK;
    end else if (cnt_x < DISP_END) begin
      region = REGION_DISP;
    end
  end

  assign sync_o = (region == REGION_SYNC);
  assign disp_o = (region == REGION_DISP);
  assign req_o  = (cnt_x >= REQ_BEG) && (cnt_x < REQ_END);
  assign pos_o  = req_o ? (cnt_q - REQ_BASE) : '0;

endmodule

// File: rtl/lcd_timing_driver.sv
// Raster timing generator: issues pixel coordinates ahead of the display window by
// DATA_LATENCY so returning pixel data lines up with data-enable, then registers all pins.
module lcd_timing_driver
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC       = T640_H_SYNC,
  parameter int unsigned H_BACK       = T640_H_BACK,
  parameter int unsigned H_DISP       = T640_H_DISP,
  parameter int unsigned H_FRONT      = T640_H_FRONT,
  parameter int unsigned V_SYNC       = T640_V_SYNC,
  parameter int unsigned V_BACK       = T640_V_BACK,
  parameter int unsigned V_DISP       = T640_V_DISP,
  parameter int unsigned V_FRONT      = T640_V_FRONT,
  parameter logic        SYNC_POL     = SYNC_ACTIVE_LOW,
  parameter int unsigned DATA_LATENCY = 1
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [23:0]        lcd_data,
  output logic [COORD_W-1:0] lcd_xpos,
  output logic [COORD_W-1:0] lcd_ypos,
  output logic               lcd_request,
  output logic               lcd_hs,
  output logic               lcd_vs,
  output logic               lcd_de,
  output logic [23:0]        lcd_rgb,
  output logic               frame_start
);

  logic               h_wrap, h_sync, h_disp, h_req;
  logic               v_wrap, v_sync, v_disp, v_req;
  logic [COORD_W-1:0] h_pos, v_pos;

  lcd_axis_counter #(
    .SYNC  (H_SYNC),
    .BACK  (H_BACK),
    .DISP  (H_DISP),
    .FRONT (H_FRONT),
    .LEAD  (DATA_LATENCY)
  ) u_h_axis (
    .clk_i  (iCLK),
    .rst_ni (iRST_N),
    .en_i   (1'b1),
    .wrap_o (h_wrap),
    .sync_o (h_sync),
    .disp_o (h_disp),
    .req_o  (h_req),
    .pos_o  (h_pos)
  );

  lcd_axis_counter #(
    .SYNC  (V_SYNC),
    .BACK  (V_BACK),
    .DISP  (V_DISP),
    .FRONT (V_FRONT),
    .LEAD  (0)
  ) u_v_axis (
    .clk_i  (iCLK),
    .rst_ni (iRST_N),
    .en_i   (h_wrap),
    .wrap_o (v_wrap),
    .sync_o (v_sync),
    .disp_o (v_disp),
    .req_o  (v_req),
    .pos_o  (v_pos)
  );

  // Request path is combinational from the counters; the lead absorbs fetch latency.
  assign lcd_request = h_req & v_req;
  assign lcd_xpos    = v_req ? h_pos : '0;
  assign lcd_ypos    = v_pos;

  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic de_q, de_d;
  rgb_t rgb_q, rgb_d;
  logic frame_q, frame_d;
  // High while the counters sit at (0,0); the registered copy is frame_start.
  logic frame_pend_q, frame_pend_d;

  always_comb begin
    hs_d         = h_sync ? SYNC_POL : ~SYNC_POL;
    vs_d         = v_sync ? SYNC_POL : ~SYNC_POL;
    de_d         = h_disp & v_disp;
    rgb_d        = de_d ? rgb_t'(lcd_data) : '0;
    frame_d      = frame_pend_q;
    frame_pend_d = h_wrap & v_wrap;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hs_q         <= ~SYNC_POL;
      vs_q         <= ~SYNC_POL;
      de_q         <= 1'b0;
      rgb_q        <= '0;
      frame_q      <= 1'b0;
      frame_pend_q <= 1'b1;
    end else begin
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      de_q         <= de_d;
      rgb_q        <= rgb_d;
      frame_q      <= frame_d;
      frame_pend_q <= frame_pend_d;
    end
  end

  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign lcd_de      = de_q;
  assign lcd_rgb     = rgb_q;
  assign frame_start = frame_q;

endmodule
